// File: rtl/rr_arb_pkg.sv
// Shared types and helpers for the round-robin arbiter: FSM state encoding,
// default requestor count and the one-hot to binary encoder for grant_id.
package rr_arb_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } rr_state_e;

    localparam int DEFAULT_NUM_REQ = 8;

    // Upper bound on requestor count the encoder helper can handle.
    localparam int MAX_REQ = 64;

    function automatic int unsigned onehot_to_bin(input logic [MAX_REQ-1:0] onehot);
        int unsigned idx;
        idx = 0;
        for (int i = 0; i < MAX_REQ; i++) begin
            if (onehot[i]) begin
                idx = idx | i;
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/ppc_unit.sv
// Log-depth parallel prefix-OR: prefix[i] = OR of data[0..i].
// Purely combinational; the clock port exists only for a uniform instance footprint.
module ppc_unit #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic [WIDTH-1:0] data,
    output logic [WIDTH-1:0] prefix
);
    localparam int LEVELS = $clog2(WIDTH);

    logic unused_clk;
    assign unused_clk = clk;

    // Kogge-Stone style: level l folds in the bit 2**l positions below.
    logic [WIDTH-1:0] stage [LEVELS+1];

    assign stage[0] = data;

    for (genvar l = 0; l < LEVELS; l++) begin : g_level
        assign stage[l+1] = stage[l] | (stage[l] << (1 << l));
    end

    assign prefix = stage[LEVELS];

endmodule

// File: rtl/rr_arbiter.sv
// Work-conserving round-robin arbiter with a registered one-hot grant that is
// held until the owner releases it; priority rotates past the last winner.
module rr_arbiter
    import rr_arb_pkg::*;
#(
    parameter int NUM_REQ = DEFAULT_NUM_REQ,
    parameter int ID_W    = $clog2(NUM_REQ)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NUM_REQ-1:0] req,
    input  logic               release_i,
    output logic [NUM_REQ-1:0] grant,
    output logic               grant_valid,
    output logic [ID_W-1:0]    grant_id
);

    rr_state_e          state;
    rr_state_e          next_state;
    logic [NUM_REQ-1:0] mask;
    logic [NUM_REQ-1:0] masked;
    logic [NUM_REQ-1:0] ppc_masked;
    logic [NUM_REQ-1:0] ppc_raw;
    logic [NUM_REQ-1:0] prefix;
    logic [NUM_REQ-1:0] winner;
    logic [MAX_REQ-1:0] winner_wide;
    logic [ID_W-1:0]    winner_id;
    logic               load_grant;
    logic               clear_grant;

    assign masked = req & mask;

    ppc_unit #(.WIDTH(NUM_REQ)) u_ppc_masked (
        .clk    (clk),
        .data   (masked),
        .prefix (ppc_masked)
    );

    ppc_unit #(.WIDTH(NUM_REQ)) u_ppc_raw (
        .clk    (clk),
        .data   (req),
        .prefix (ppc_raw)
    );

    // Fall back to the raw requests when nobody above the last winner asks.
    assign prefix = (masked != '0) ? ppc_masked : ppc_raw;
    assign winner = prefix & ~(prefix << 1);

    always_comb begin
        winner_wide                = '0;
        winner_wide[NUM_REQ-1:0]   = winner;
    end

    assign winner_id = ID_W'(onehot_to_bin(winner_wide));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (req != '0) next_state = BUSY;
            BUSY:    if (release_i) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        load_grant  = 1'b0;
        clear_grant = 1'b0;
        case (state)
            IDLE:    load_grant  = (req != '0);
            BUSY:    clear_grant = release_i;
            default: ;
        endcase
    end

    // On release, only indices strictly above the departing owner stay eligible.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            grant       <= '0;
            grant_valid <= 1'b0;
            grant_id    <= '0;
            mask        <= '1;
        end else if (load_grant) begin
            grant       <= winner;
            grant_valid <= 1'b1;
            grant_id    <= winner_id;
        end else if (clear_grant) begin
            grant       <= '0;
            grant_valid <= 1'b0;
            grant_id    <= '0;
            mask        <= ~((grant << 1) - NUM_REQ'(1));
        end
    end

endmodule

// File: tb/tb_rr_arbiter.sv
// Self-checking bench for rr_arbiter: directed vector table, hand-written reset
// corner cases and randomized traffic against a round-robin reference model.
module tb_rr_arbiter;

    localparam int N  = 8;
    localparam int IW = 3;

    logic          clk;
    logic          rst_n;
    logic [N-1:0]  req;
    logic          release_i;
    logic [N-1:0]  grant;
    logic          grant_valid;
    logic [IW-1:0] grant_id;

    int n_checks;
    int n_fail;

    typedef struct {
        logic [N-1:0]  req;
        logic          rel;
        logic [N-1:0]  exp_grant;
        logic [IW-1:0] exp_id;
    } vec_t;

    vec_t vecs [17];

    // Reference model state: who holds the grant and who last released it.
    bit m_busy;
    int m_id;
    int m_last;

    rr_arbiter #(.NUM_REQ(N)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req         (req),
        .release_i   (release_i),
        .grant       (grant),
        .grant_valid (grant_valid),
        .grant_id    (grant_id)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Next owner: first requestor after the last winner, else lowest requestor.
    function automatic int pick(input logic [N-1:0] r, input int last);
        for (int i = last + 1; i < N; i++) begin
            if (r[i]) return i;
        end
        for (int i = 0; i < N; i++) begin
            if (r[i]) return i;
        end
        return -1;
    endfunction

    task automatic applyStimulus(input logic [N-1:0] r, input logic rel);
        req       = r;
        release_i = rel;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic checkOutput(input string name, input logic [N-1:0] eg,
                               input logic [IW-1:0] eid, input logic ev);
        n_checks++;
        if (grant !== eg || grant_id !== eid || grant_valid !== ev) begin
            n_fail++;
            $display("[TB] FAIL %s: got grant=%b id=%0d valid=%b, expected grant=%b id=%0d valid=%b",
                     name, grant, grant_id, grant_valid, eg, eid, ev);
        end
    endtask

    task automatic doReset();
        req       = '0;
        release_i = 1'b0;
        rst_n     = 1'b0;
        repeat (2) @(negedge clk);
        rst_n     = 1'b1;
        m_busy    = 1'b0;
        m_id      = 0;
        m_last    = -1;
    endtask

    initial begin
        logic [N-1:0] eg;
        logic [N-1:0] r;
        logic         rel;

        n_checks = 0;
        n_fail   = 0;

        vecs[0]  = '{8'hA4, 1'b0, 8'h04, 3'd2};
        vecs[1]  = '{8'hA4, 1'b1, 8'h00, 3'd0};
        vecs[2]  = '{8'hA4, 1'b0, 8'h20, 3'd5};
        vecs[3]  = '{8'hA4, 1'b1, 8'h00, 3'd0};
        vecs[4]  = '{8'hA4, 1'b0, 8'h80, 3'd7};
        vecs[5]  = '{8'hA4, 1'b1, 8'h00, 3'd0};
        vecs[6]  = '{8'hA4, 1'b0, 8'h04, 3'd2};
        vecs[7]  = '{8'hA4, 1'b1, 8'h00, 3'd0};
        vecs[8]  = '{8'h01, 1'b0, 8'h01, 3'd0};
        vecs[9]  = '{8'h01, 1'b1, 8'h00, 3'd0};
        vecs[10] = '{8'h08, 1'b0, 8'h08, 3'd3};
        vecs[11] = '{8'h00, 1'b0, 8'h08, 3'd3};
        vecs[12] = '{8'h00, 1'b0, 8'h08, 3'd3};
        vecs[13] = '{8'h00, 1'b0, 8'h08, 3'd3};
        vecs[14] = '{8'h00, 1'b0, 8'h08, 3'd3};
        vecs[15] = '{8'h00, 1'b0, 8'h08, 3'd3};
        vecs[16] = '{8'h00, 1'b1, 8'h00, 3'd0};

        doReset();
        checkOutput("reset_state", 8'h00, 3'd0, 1'b0);

        for (int i = 0; i < 17; i++) begin
            applyStimulus(vecs[i].req, vecs[i].rel);
            checkOutput($sformatf("vec[%0d]", i), vecs[i].exp_grant, vecs[i].exp_id,
                        vecs[i].exp_grant != '0);
        end

        // Release in IDLE is ignored; an all-ones request then goes to index 0.
        doReset();
        applyStimulus(8'h00, 1'b1);
        checkOutput("idle_release", 8'h00, 3'd0, 1'b0);
        applyStimulus(8'hFF, 1'b0);
        checkOutput("all_req_after_reset", 8'h01, 3'd0, 1'b1);
        applyStimulus(8'hFF, 1'b1);
        checkOutput("release_idx0", 8'h00, 3'd0, 1'b0);
        applyStimulus(8'h40, 1'b0);
        checkOutput("grant_idx6", 8'h40, 3'd6, 1'b1);

        // Asynchronous reset while BUSY, observed before any clock edge.
        #2 rst_n = 1'b0;
        #1 checkOutput("async_reset", 8'h00, 3'd0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        applyStimulus(8'hC0, 1'b0);
        checkOutput("post_reset_c0", 8'h40, 3'd6, 1'b1);
        applyStimulus(8'hC0, 1'b1);
        checkOutput("post_reset_release", 8'h00, 3'd0, 1'b0);
        applyStimulus(8'hC0, 1'b0);
        checkOutput("post_reset_next7", 8'h80, 3'd7, 1'b1);

        // Randomized traffic against the reference model.
        doReset();
        for (int c = 0; c < 400; c++) begin
            r   = ($urandom_range(3) == 0) ? '0 : N'($urandom);
            rel = ($urandom_range(2) == 0);
            if (!m_busy) begin
                if (r != '0) begin
                    m_id   = pick(r, m_last);
                    m_busy = 1'b1;
                end
            end else if (rel) begin
                m_busy = 1'b0;
                m_last = m_id;
            end
            applyStimulus(r, rel);
            eg = '0;
            if (m_busy) eg[m_id] = 1'b1;
            checkOutput($sformatf("random[%0d]", c), eg,
                        m_busy ? IW'(m_id) : '0, m_busy);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
